// File: rtl/sp3_tx_pkg.sv
// sp3_tx_pkg: shared constants and types for the SPROCKET3 dual transmit path.
// Holds word width, FIFO depth, idle filler word, slip width, PRBS7 seed/taps
// and the slot enum used by the interleaver.
package sp3_tx_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SLIP_W     = $clog2(WORD_W);
  localparam int unsigned IDLE_CNT_W = 16;

  localparam logic [WORD_W-1:0] IDLE_WORD = 32'hAAAA_AAAA;

  // PRBS7 x^7 + x^6 + 1: feedback from state bits 6 and 5
  localparam logic [6:0]  PRBS7_SEED  = 7'h7F;
  localparam int unsigned PRBS7_TAP_A = 6;
  localparam int unsigned PRBS7_TAP_B = 5;

  typedef enum logic {
    SLOT_A = 1'b0,
    SLOT_B = 1'b1
  } slot_e;

endpackage

// File: rtl/sp3_dual_tx_if.sv
// sp3_dual_tx_if: per-channel valid/ready word streams feeding sp3_dual_tx.
//   word_a_i/valid_a_i/ready_a_o : channel A stream
//   word_b_i/valid_b_i/ready_b_o : channel B stream
// master = word source, slave = transmitter.
interface sp3_dual_tx_if;
  import sp3_tx_pkg::*;

  logic [WORD_W-1:0] word_a_i;
  logic              valid_a_i;
  logic              ready_a_o;
  logic [WORD_W-1:0] word_b_i;
  logic              valid_b_i;
  logic              ready_b_o;

  modport master (
    output word_a_i, valid_a_i, word_b_i, valid_b_i,
    input  ready_a_o, ready_b_o
  );

  modport slave (
    input  word_a_i, valid_a_i, word_b_i, valid_b_i,
    output ready_a_o, ready_b_o
  );

endinterface

// File: rtl/sp3_tx_chan.sv
// sp3_tx_chan: one transmit channel - word FIFO, idle insertion with a
// saturating idle counter, programmable bit-slip shifter and history word.
// Optional PRBS7 source when SP3_TX_PRBS_EN is defined.
// Ports:
//   mgtclk, reset   : clock, synchronous active-high reset
//   prbs_en_i       : (SP3_TX_PRBS_EN only) source PRBS7 instead of FIFO
//   word_i/valid_i/ready_o : input stream, ready from registered count only
//   slot_i          : this channel owns the current output slot
//   bitslip_i       : increment bit delay (mod WORD_W) from the next slot
//   word_c_o        : slipped word for the current slot (combinational)
//   slip_o, idle_cnt_o : current bit delay, idle insertions
module sp3_tx_chan
  import sp3_tx_pkg::*;
(
  input  logic                  mgtclk,
  input  logic                  reset,
`ifdef SP3_TX_PRBS_EN
  input  logic                  prbs_en_i,
`endif
  input  logic [WORD_W-1:0]     word_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  slot_i,
  input  logic                  bitslip_i,
  output logic [WORD_W-1:0]     word_c_o,
  output logic [SLIP_W-1:0]     slip_o,
  output logic [IDLE_CNT_W-1:0] idle_cnt_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WORD_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SLIP_W-1:0]     slip_q, slip_d;
  logic [WORD_W-1:0]     prev_q, prev_d;
  logic [IDLE_CNT_W-1:0] idle_q, idle_d;
  logic [WORD_W-1:0]     cur;
  logic                  push, pop, idle_ins, prbs_mode;

`ifdef SP3_TX_PRBS_EN
  logic [6:0]        lfsr_q, lfsr_d;
  logic [WORD_W-1:0] prbs_word;

  assign prbs_mode = prbs_en_i;

  // Advance WORD_W bits; first generated bit lands in the MSB
  always_comb begin
    lfsr_d    = lfsr_q;
    prbs_word = '0;
    for (int i = int'(WORD_W) - 1; i >= 0; i--) begin
      prbs_word[i] = lfsr_d[PRBS7_TAP_A] ^ lfsr_d[PRBS7_TAP_B];
      lfsr_d       = {lfsr_d[5:0], prbs_word[i]};
    end
  end

  always_ff @(posedge mgtclk) begin
    if (reset) begin
      lfsr_q <= PRBS7_SEED;
    end else if (slot_i && prbs_mode) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign prbs_mode = 1'b0;
`endif

  assign ready_o    = (count_q < CNT_W'(FIFO_DEPTH));
  assign slip_o     = slip_q;
  assign idle_cnt_o = idle_q;

  // Pop/idle decisions and next-state for FIFO, slip, history and counter
  always_comb begin
    push     = valid_i & ready_o;
    pop      = slot_i & ~prbs_mode & (count_q != '0);
    idle_ins = slot_i & ~prbs_mode & (count_q == '0);

    cur = (count_q != '0) ? mem_q[rd_ptr_q] : IDLE_WORD;
`ifdef SP3_TX_PRBS_EN
    if (prbs_mode) cur = prbs_word;
`endif

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    slip_d = slip_q;
    if (bitslip_i) begin
      slip_d = (slip_q == SLIP_W'(WORD_W - 1)) ? '0 : slip_q + SLIP_W'(1);
    end

    prev_d = slot_i ? cur : prev_q;

    idle_d = idle_q;
    if (idle_ins && (idle_q != '1)) idle_d = idle_q + IDLE_CNT_W'(1);

    // Upper half of {cur, prev} shifted left by the bit delay
    word_c_o = WORD_W'(({cur, prev_q} << slip_q) >> WORD_W);
  end

  always_ff @(posedge mgtclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      slip_q   <= '0;
      prev_q   <= '0;
      idle_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      slip_q   <= slip_d;
      prev_q   <= prev_d;
      idle_q   <= idle_d;
    end
  end

  // Storage needs no reset; pointers and count define validity
  always_ff @(posedge mgtclk) begin
    if (push) mem_q[wr_ptr_q] <= word_i;
  end

endmodule

// File: rtl/sp3_dual_tx.sv
// sp3_dual_tx: interleaves two buffered, bit-slipped channel streams into one
// MGT user word, alternating A/B slots every mgtclk cycle (A first after reset).
// Optional PRBS7 source selected by macro SP3_TX_PRBS_EN (adds prbs_en_i).
// Ports:
//   mgtclk, reset            : clock, synchronous active-high reset
//   bus (slave)              : channel A/B valid/ready word streams
//   bitslip_a_i, bitslip_b_i : per-channel bit delay increment pulses
//   mgtword_o, slot_b_o      : registered output word and its slot owner
//   slip_a_o, slip_b_o       : current bit delays
//   idle_cnt_a_o/_b_o        : saturating idle insertion counts
module sp3_dual_tx
  import sp3_tx_pkg::*;
(
  input  logic                  mgtclk,
  input  logic                  reset,
`ifdef SP3_TX_PRBS_EN
  input  logic                  prbs_en_i,
`endif
  sp3_dual_tx_if.slave          bus,
  input  logic                  bitslip_a_i,
  input  logic                  bitslip_b_i,
  output logic [WORD_W-1:0]     mgtword_o,
  output logic                  slot_b_o,
  output logic [SLIP_W-1:0]     slip_a_o,
  output logic [SLIP_W-1:0]     slip_b_o,
  output logic [IDLE_CNT_W-1:0] idle_cnt_a_o,
  output logic [IDLE_CNT_W-1:0] idle_cnt_b_o
);

  slot_e             sel_q, sel_d;
  logic [WORD_W-1:0] word_a_c, word_b_c;
  logic [WORD_W-1:0] mgtword_d;
  logic              slot_b_d;

  sp3_tx_chan u_chan_a (
    .mgtclk     (mgtclk),
    .reset      (reset),
`ifdef SP3_TX_PRBS_EN
    .prbs_en_i  (prbs_en_i),
`endif
    .word_i     (bus.word_a_i),
    .valid_i    (bus.valid_a_i),
    .ready_o    (bus.ready_a_o),
    .slot_i     (sel_q == SLOT_A),
    .bitslip_i  (bitslip_a_i),
    .word_c_o   (word_a_c),
    .slip_o     (slip_a_o),
    .idle_cnt_o (idle_cnt_a_o)
  );

  sp3_tx_chan u_chan_b (
    .mgtclk     (mgtclk),
    .reset      (reset),
`ifdef SP3_TX_PRBS_EN
    .prbs_en_i  (prbs_en_i),
`endif
    .word_i     (bus.word_b_i),
    .valid_i    (bus.valid_b_i),
    .ready_o    (bus.ready_b_o),
    .slot_i     (sel_q == SLOT_B),
    .bitslip_i  (bitslip_b_i),
    .word_c_o   (word_b_c),
    .slip_o     (slip_b_o),
    .idle_cnt_o (idle_cnt_b_o)
  );

  // Slot sequencer and output mux
  always_comb begin
    sel_d     = sel_q;
    mgtword_d = word_a_c;
    slot_b_d  = 1'b0;
    case (sel_q)
      SLOT_A: sel_d = SLOT_B;
      SLOT_B: begin
        sel_d     = SLOT_A;
        mgtword_d = word_b_c;
        slot_b_d  = 1'b1;
      end
      default: sel_d = SLOT_A;
    endcase
  end

  always_ff @(posedge mgtclk) begin
    if (reset) begin
      sel_q     <= SLOT_A;
      mgtword_o <= '0;
      slot_b_o  <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      mgtword_o <= mgtword_d;
      slot_b_o  <= slot_b_d;
    end
  end

endmodule
